// File: rtl/dma_req_queue_pkg.sv
// Shared types for the DMA descriptor queue.
// Descriptor layout and error-pulse bit positions.
package dma_req_queue_pkg;

  localparam int unsigned DescAddrW = 64;
  localparam int unsigned DescLenW  = 64;

  typedef struct packed {
    logic [DescAddrW-1:0] src;
    logic [DescAddrW-1:0] dst;
    logic [DescLenW-1:0]  len;
  } desc_t;

  localparam int unsigned ErrW       = 2;
  localparam int unsigned ErrZeroBit = 0;
  localparam int unsigned ErrSpurBit = 1;

endpackage

// File: rtl/dma_req_fifo.sv
// Register FIFO, Depth entries, wrap-bit pointers.
// push/pop with data, full/empty flags and usage count.
module dma_req_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW:0]    usage_o
);

  logic [PtrW:0]    wr_q;
  logic [PtrW:0]    rd_q;
  logic [Width-1:0] mem_q [Depth];

  // storage is cleared too so the head reads zero
  // while the queue is empty after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[PtrW-1:0]] <= data_i;
        wr_q <= wr_q + (PtrW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rd_q <= rd_q + (PtrW+1)'(1);
      end
    end
  end

  assign full_o  = (wr_q[PtrW] != rd_q[PtrW]) &&
                   (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign usage_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[PtrW-1:0]];

endmodule

// File: rtl/dma_req_queue.sv
// DMA descriptor queue: ID assignment, in-order issue
// with bounded inflight, completion and error tracking.
module dma_req_queue
  import dma_req_queue_pkg::*;
#(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned LenWidth    = 64,
  parameter int unsigned Depth       = 4,
  parameter int unsigned MaxInflight = 2,
  parameter int unsigned IdWidth     = 32,
  localparam int unsigned IfW = $clog2(MaxInflight+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] src_addr_i,
  input  logic [AddrWidth-1:0] dst_addr_i,
  input  logic [LenWidth-1:0]  length_i,
  input  logic                 submit_valid_i,
  output logic                 submit_ready_o,
  output logic [IdWidth-1:0]   submit_id_o,
  output logic [AddrWidth-1:0] req_src_addr_o,
  output logic [AddrWidth-1:0] req_dst_addr_o,
  output logic [LenWidth-1:0]  req_length_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  input  logic                 trans_complete_i,
  output logic [IdWidth-1:0]   next_id_o,
  output logic [IdWidth-1:0]   done_id_o,
  output logic [IfW-1:0]       inflight_o,
  output logic                 idle_o,
  output logic                 err_zero_o,
  output logic                 err_spurious_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  desc_t push_desc;
  desc_t head_desc;

  logic            fifo_full;
  logic            fifo_empty;
  logic [PtrW:0]   fifo_usage;
  logic            accept;
  logic            zero_len;
  logic            push;
  logic            issue;
  logic            cmpl;
  logic            spur;

  logic [IdWidth-1:0] next_id_q;
  logic [IdWidth-1:0] done_id_q;
  logic [IfW-1:0]     inflight_q;
  logic [IfW-1:0]     inflight_d;
  logic [ErrW-1:0]    err_q;

  assign zero_len       = (length_i == '0);
  assign submit_ready_o = !fifo_full;
  assign accept         = submit_valid_i && submit_ready_o;
  assign push           = accept && !zero_len;

  always_comb begin
    push_desc     = '0;
    push_desc.src = DescAddrW'(src_addr_i);
    push_desc.dst = DescAddrW'(dst_addr_i);
    push_desc.len = DescLenW'(length_i);
  end

  dma_req_fifo #(
    .Width ($bits(desc_t)),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_desc),
    .pop_i   (issue),
    .data_o  (head_desc),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  assign req_valid_o = !fifo_empty &&
                       (inflight_q < IfW'(MaxInflight));
  assign issue = req_valid_o && req_ready_i;

  // a completion is legal if something is outstanding
  // or being issued in the same cycle
  assign cmpl = trans_complete_i &&
                ((inflight_q != '0) || issue);
  assign spur = trans_complete_i &&
                (inflight_q == '0) && !issue;

  assign req_src_addr_o = head_desc.src[AddrWidth-1:0];
  assign req_dst_addr_o = head_desc.dst[AddrWidth-1:0];
  assign req_length_o   = head_desc.len[LenWidth-1:0];

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, cmpl})
      2'b10:   inflight_d = inflight_q + IfW'(1);
      2'b01:   inflight_d = inflight_q - IfW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      next_id_q  <= '0;
      done_id_q  <= '0;
      inflight_q <= '0;
      err_q      <= '0;
    end else begin
      if (push) begin
        next_id_q <= next_id_q + IdWidth'(1);
      end
      if (cmpl) begin
        done_id_q <= done_id_q + IdWidth'(1);
      end
      inflight_q        <= inflight_d;
      err_q[ErrZeroBit] <= accept && zero_len;
      err_q[ErrSpurBit] <= spur;
    end
  end

  assign submit_id_o    = next_id_q + IdWidth'(1);
  assign next_id_o      = next_id_q;
  assign done_id_o      = done_id_q;
  assign inflight_o     = inflight_q;
  assign idle_o         = (fifo_usage == '0) &&
                          (inflight_q == '0);
  assign err_zero_o     = err_q[ErrZeroBit];
  assign err_spurious_o = err_q[ErrSpurBit];

endmodule

// File: tb/tb_dma_req_queue.sv
// Directed bench for dma_req_queue with an issue
// scoreboard; IdWidth=4 so ID wrap is reachable.
module tb_dma_req_queue;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   src = '0;
  logic [63:0]   dst = '0;
  logic [63:0]   len = '0;
  logic          sv  = 1'b0;
  logic          rr  = 1'b0;
  logic          tc  = 1'b0;

  logic          sub_ready;
  logic [IW-1:0] sub_id;
  logic [63:0]   req_src;
  logic [63:0]   req_dst;
  logic [63:0]   req_len;
  logic          req_valid;
  logic [IW-1:0] next_id;
  logic [IW-1:0] done_id;
  logic [1:0]    inflight;
  logic          idle;
  logic          err_zero;
  logic          err_spur;

  dma_req_queue #(
    .AddrWidth   (64),
    .LenWidth    (64),
    .Depth       (4),
    .MaxInflight (2),
    .IdWidth     (IW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .src_addr_i       (src),
    .dst_addr_i       (dst),
    .length_i         (len),
    .submit_valid_i   (sv),
    .submit_ready_o   (sub_ready),
    .submit_id_o      (sub_id),
    .req_src_addr_o   (req_src),
    .req_dst_addr_o   (req_dst),
    .req_length_o     (req_len),
    .req_valid_o      (req_valid),
    .req_ready_i      (rr),
    .trans_complete_i (tc),
    .next_id_o        (next_id),
    .done_id_o        (done_id),
    .inflight_o       (inflight),
    .idle_o           (idle),
    .err_zero_o       (err_zero),
    .err_spurious_o   (err_spur)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    logic [63:0] d;
    logic [63:0] l;
  } exp_t;

  exp_t          sb [$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [IW-1:0] nid = '0;
  logic [IW-1:0] did = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic submit(input logic [63:0] s,
                        input logic [63:0] d,
                        input logic [63:0] l,
                        output bit acc);
    src = s;
    dst = d;
    len = l;
    sv  = 1'b1;
    acc = sub_ready;
    if (acc && l != 0) begin
      sb.push_back('{s, d, l});
      nid++;
    end
    tick();
    sv = 1'b0;
  endtask

  task automatic drain(input string tag);
    int b;
    b  = 0;
    rr = 1'b1;
    while ((sb.size() != 0 || inflight != 0) && b < 40) begin
      tc = (inflight != 0);
      if (tc) did++;
      chk({tag, "_infl_le2"}, 64'(inflight <= 2), 1);
      tick();
      b++;
    end
    tc = 1'b0;
    chk({tag, "_budget"}, 64'(b < 40), 1);
    chk({tag, "_done_id"}, done_id, did);
    chk({tag, "_idle"}, idle, 1);
  endtask

  // every handshake at the next edge pops the oldest
  // expected descriptor
  always @(negedge clk) begin
    if (!rst && req_valid && rr) begin
      if (sb.size() == 0) begin
        chk("iss_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_src", req_src, e.s);
        chk("iss_dst", req_dst, e.d);
        chk("iss_len", req_len, e.l);
      end
    end
  end

  initial begin
    bit a;
    bit r5;
    int nacc;
    int cnt;
    int b;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", sub_ready, 1);
    chk("rst_valid", req_valid, 0);
    chk("rst_src", req_src, 0);
    chk("rst_len", req_len, 0);
    chk("rst_idle", idle, 1);
    chk("rst_sub_id", sub_id, 1);
    chk("rst_next_id", next_id, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err_zero", err_zero, 0);
    chk("rst_err_spur", err_spur, 0);

    // single descriptor, backend ready
    rr = 1'b1;
    submit(64'h1000, 64'h2000, 64'd64, a);
    chk("t1_acc", a, 1);
    chk("t1_next_id", next_id, nid);
    chk("t1_valid", req_valid, 1);
    chk("t1_src", req_src, 64'h1000);
    chk("t1_dst", req_dst, 64'h2000);
    chk("t1_len", req_len, 64'd64);
    chk("t1_busy", idle, 0);
    tick();
    chk("t1_inflight", inflight, 1);
    chk("t1_valid_off", req_valid, 0);
    tc = 1'b1;
    did++;
    tick();
    tc = 1'b0;
    chk("t1_done_id", done_id, 1);
    chk("t1_inflight0", inflight, 0);
    chk("t1_idle", idle, 1);

    // fill with backend stalled
    rr = 1'b0;
    nacc = 0;
    r5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      submit(64'h3000 + 64'(i * 16), 64'h4000 + 64'(i * 16),
             64'd128 + 64'(i), a);
      if (a) nacc++;
      if (i == 4) r5 = a;
    end
    chk("t2_acc", nacc, 4);
    chk("t2_ready5", r5, 0);
    chk("t2_full", sub_ready, 0);
    chk("t2_next_id", next_id, nid);
    chk("t2_next_val", next_id, 5);
    drain("t2");

    // inflight cap with no completions
    rr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      submit(64'h5000 + 64'(i), 64'h6000 + 64'(i),
             64'd8 + 64'(i), a);
    end
    chk("t3_inflight2", inflight, 2);
    chk("t3_valid_off", req_valid, 0);
    chk("t3_busy", idle, 0);
    tc = 1'b1;
    did++;
    tick();
    tc = 1'b0;
    chk("t3_inflight1", inflight, 1);
    chk("t3_valid_on", req_valid, 1);
    tick();
    chk("t3_inflight_re2", inflight, 2);
    chk("t3_valid_off2", req_valid, 0);
    drain("t3");

    // zero-length submit is dropped
    submit(64'h7000, 64'h8000, 64'd0, a);
    chk("t4_acc", a, 1);
    chk("t4_err_zero", err_zero, 1);
    chk("t4_next_id", next_id, nid);
    chk("t4_valid", req_valid, 0);
    tick();
    chk("t4_err_zero_off", err_zero, 0);

    // spurious completion on idle block
    tc = 1'b1;
    tick();
    tc = 1'b0;
    chk("t5_err_spur", err_spur, 1);
    chk("t5_done_id", done_id, did);
    tick();
    chk("t5_err_spur_off", err_spur, 0);

    // issue and completion in the same cycle
    submit(64'h9000, 64'hA000, 64'd16, a);
    tick();
    chk("t5_inflight1", inflight, 1);
    submit(64'h9100, 64'hA100, 64'd32, a);
    chk("t5_valid", req_valid, 1);
    tc = 1'b1;
    did++;
    tick();
    tc = 1'b0;
    chk("t5_inflight_same", inflight, 1);
    chk("t5_done_inc", done_id, did);
    chk("t5_no_spur", err_spur, 0);
    drain("t5");

    // reset with work queued and outstanding
    for (int i = 0; i < 5; i++) begin
      submit(64'hB000 + 64'(i), 64'hC000 + 64'(i),
             64'd4 + 64'(i), a);
    end
    chk("t6_inflight2", inflight, 2);
    chk("t6_valid_off", req_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    nid = '0;
    did = '0;
    chk("t6_idle", idle, 1);
    chk("t6_next_id", next_id, 0);
    chk("t6_done_id", done_id, 0);
    chk("t6_inflight", inflight, 0);
    chk("t6_valid", req_valid, 0);
    chk("t6_ready", sub_ready, 1);

    // ID wrap at 2^IW submits
    cnt = 0;
    b = 0;
    rr = 1'b1;
    while (cnt < 16 && b < 80) begin
      tc = (inflight != 0);
      if (tc) did++;
      submit(64'hD000 + 64'(cnt), 64'hE000 + 64'(cnt),
             64'(cnt + 1), a);
      if (a) cnt++;
      b++;
    end
    tc = 1'b0;
    chk("t7_budget", 64'(b < 80), 1);
    chk("t7_next_id", next_id, nid);
    chk("t7_wrap0", next_id, 0);
    chk("t7_sub_id", sub_id, 1);
    drain("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
